// File: rtl/rom_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : rom_fetch_unit
// Brief    : Program-ROM fetch initiator with FWFT prefetch FIFO and branch flush
// Revision : 1.0
// ============================================================================
module rom_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA,
  input  logic                  BRANCH_EN,
  input  logic [ADDR_WIDTH-1:0] BRANCH_ADDR,
  output logic                  INSTR_VALID,
  output logic [DATA_WIDTH-1:0] INSTR_DATA,
  output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
  input  logic                  INSTR_READY
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_addr;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [c_CNT_W:0]      w_occupancy;

  assign INSTR_VALID = (r_count != '0);
  assign INSTR_DATA  = r_mem_data[r_rd_ptr];
  assign INSTR_ADDR  = r_mem_addr[r_rd_ptr];

  assign ROM_ADDR = BRANCH_EN ? BRANCH_ADDR : r_fetch_pc;
  assign w_pop    = INSTR_VALID & INSTR_READY & ~BRANCH_EN;
  assign w_push   = r_inflight & ~BRANCH_EN;

  // Counting the in-flight read as occupied means a returning byte always finds room.
  assign w_occupancy = {1'b0, r_count} + (c_CNT_W + 1)'(r_inflight) - (c_CNT_W + 1)'(w_pop);
  assign w_issue     = ~RESET & (BRANCH_EN | (w_occupancy < c_DEPTH));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fetch_pc      <= RESET_ADDR;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else if (w_issue) begin
      r_fetch_pc      <= ROM_ADDR + ADDR_WIDTH'(1);
      r_inflight      <= 1'b1;
      r_inflight_addr <= ROM_ADDR;
    end else begin
      r_inflight      <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || BRANCH_EN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_push);
      r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop);
      r_count  <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_addr[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_ptr] <= ROM_DATA;
      r_mem_addr[r_wr_ptr] <= r_inflight_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_unit.sv
`default_nettype none
// Testbench for rom_fetch_unit: directed phases, expected bytes queued by stimulus,
// checked by negedge monitors on every accepted byte.
module tb_rom_fetch_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, br_en, ready, valid;
  logic [7:0] br_addr, rom_addr, rom_data, idata, iaddr;
  logic       rst_fe, ready_fe, valid_fe;
  logic [7:0] rom_addr_fe, rom_data_fe, idata_fe, iaddr_fe;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_fe_q[$];
  logic [15:0] head, head_fe;

  rom_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .FIFO_DEPTH(2), .RESET_ADDR(8'h00)) u_dut (
    .CLK(clk), .RESET(rst), .ROM_ADDR(rom_addr), .ROM_DATA(rom_data),
    .BRANCH_EN(br_en), .BRANCH_ADDR(br_addr), .INSTR_VALID(valid),
    .INSTR_DATA(idata), .INSTR_ADDR(iaddr), .INSTR_READY(ready)
  );

  rom_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .FIFO_DEPTH(2), .RESET_ADDR(8'hFE)) u_dut_fe (
    .CLK(clk), .RESET(rst_fe), .ROM_ADDR(rom_addr_fe), .ROM_DATA(rom_data_fe),
    .BRANCH_EN(1'b0), .BRANCH_ADDR(8'h00), .INSTR_VALID(valid_fe),
    .INSTR_DATA(idata_fe), .INSTR_ADDR(iaddr_fe), .INSTR_READY(ready_fe)
  );

  // Registered-read ROM models: rom[i] = i ^ 8'hA5
  always @(posedge clk) rom_data    <= rom_addr ^ 8'hA5;
  always @(posedge clk) rom_data_fe <= rom_addr_fe ^ 8'hA5;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid && ready && !br_en) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got addr %h data %h, expected none", iaddr, idata);
      end else begin
        head = exp_q.pop_front();
        check("stream", {iaddr, idata}, head);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_fe && valid_fe && ready_fe) begin
      if (exp_fe_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte_fe: got addr %h data %h, expected none", iaddr_fe, idata_fe);
      end else begin
        head_fe = exp_fe_q.pop_front();
        check("stream_fe", {iaddr_fe, idata_fe}, head_fe);
      end
    end
  end

  task automatic push_exp(input logic [7:0] start, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 8'(i);
      exp_q.push_back({a, a ^ 8'hA5});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until every expected byte is consumed, then stops the consumer.
  task automatic drain(input string name, input int exp_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    ready = 1'b0;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d bytes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    check(name, 16'(n), 16'(exp_cyc));
  endtask

  initial begin
    int n;
    rst = 1'b1; br_en = 1'b0; br_addr = 8'h00; ready = 1'b0;
    rst_fe = 1'b1; ready_fe = 1'b1;
    repeat (3) tick();
    check("reset_valid", 16'(valid), 16'h0);
    check("reset_data",  16'(idata), 16'h0);
    check("reset_addr",  16'(iaddr), 16'h0);
    check("reset_romaddr", 16'(rom_addr), 16'h0);

    // Start-up and steady streaming: 2-cycle latency then one byte per cycle
    push_exp(8'h00, 8);
    rst = 1'b0; ready = 1'b1;
    drain("startup_cycles", 10);

    // Back-pressure: FIFO fills, fetch stalls
    repeat (10) tick();
    check("hold_valid",   16'(valid),    16'h1);
    check("hold_addr",    16'(iaddr),    16'h08);
    check("hold_data",    16'(idata),    16'h08 ^ 16'hA5);
    check("hold_romaddr", 16'(rom_addr), 16'h0A);
    push_exp(8'h08, 8);
    ready = 1'b1;
    drain("resume_cycles", 8);

    // Branch with full FIFO
    repeat (4) tick();
    br_en = 1'b1; br_addr = 8'h40;
    #1;
    check("branch_romaddr", 16'(rom_addr), 16'h40);
    tick();
    check("branch_gap_valid", 16'(valid), 16'h0);
    br_en = 1'b0; ready = 1'b1;
    push_exp(8'h40, 8);
    drain("branch_cycles", 9);

    // Back-to-back branches: only the second target is delivered
    repeat (4) tick();
    br_en = 1'b1; br_addr = 8'h10; ready = 1'b1;
    tick();
    br_addr = 8'h20;
    push_exp(8'h20, 4);
    tick();
    br_en = 1'b0;
    check("b2b_gap_valid", 16'(valid), 16'h0);
    drain("b2b_cycles", 5);

    // Reset mid-stream with full FIFO
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("midrst_valid",   16'(valid),    16'h0);
    check("midrst_data",    16'(idata),    16'h0);
    check("midrst_addr",    16'(iaddr),    16'h0);
    check("midrst_romaddr", 16'(rom_addr), 16'h0);
    push_exp(8'h00, 4);
    rst = 1'b0; ready = 1'b1;
    drain("midrst_cycles", 6);

    // Non-zero reset address with wrap
    check("fe_reset_valid",   16'(valid_fe),    16'h0);
    check("fe_reset_romaddr", 16'(rom_addr_fe), 16'hFE);
    exp_fe_q.push_back({8'hFE, 8'h5B});
    exp_fe_q.push_back({8'hFF, 8'h5A});
    exp_fe_q.push_back({8'h00, 8'hA5});
    exp_fe_q.push_back({8'h01, 8'hA4});
    rst_fe = 1'b0;
    n = 0;
    while (exp_fe_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    ready_fe = 1'b0;
    if (exp_fe_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL fe_timeout: got %0d bytes outstanding, expected 0", exp_fe_q.size());
    end
    check("fe_cycles", 16'(n), 16'd6);

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
